// File: rtl/stonyman_pkg.sv
// rtl/stonyman_pkg.sv - Stonyman register map, FSM encoding and pixel step (STONYMAN_DOWNSAMPLE_EN)
package stonyman_pkg;

    localparam int MAX_RESOLUTION = 112;

    localparam logic [2:0] COLSEL = 3'd0;
    localparam logic [2:0] ROWSEL = 3'd1;
    localparam logic [2:0] VSW    = 3'd2;
    localparam logic [2:0] HSW    = 3'd3;
    localparam logic [2:0] VREF   = 3'd4;
    localparam logic [2:0] CONFIG = 3'd5;
    localparam logic [2:0] NBIAS  = 3'd6;
    localparam logic [2:0] AOBIAS = 3'd7;

    localparam int PULSE_COUNT_W = 4;

`ifdef STONYMAN_DOWNSAMPLE_EN
    localparam int PIXEL_STEP = 2;
`else
    localparam int PIXEL_STEP = 1;
`endif

    typedef enum logic [3:0] {
        IDLE, SEL_ROW, CLR_ROW, STEP_ROW, NEWLINE, SEL_COL, CLR_COL,
        SETTLE, CAPTURE, WAIT_ADC, STEP_COL, NEXT_ROW, DONE
    } state_t;

    typedef enum logic [1:0] {PIN_RESP, PIN_INCP, PIN_RESV, PIN_INCV} pin_t;

endpackage

// File: rtl/stonyman_pulse_gen.sv
// rtl/stonyman_pulse_gen.sv - emits N high/low pulses on one selected Stonyman control pin
module stonyman_pulse_gen
    import stonyman_pkg::*;
#(
    parameter int PULSE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  pin_t                     pin,
    input  logic [PULSE_COUNT_W-1:0] count,
    output logic                     done,
    output logic                     resp,
    output logic                     incp,
    output logic                     resv,
    output logic                     incv
);

    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(PULSE_CYCLES - 1);

    pin_t                     sel;
    logic                     active;
    logic                     high;
    logic                     zero_done;
    logic [PW-1:0]            phase;
    logic [PULSE_COUNT_W-1:0] remaining;
    logic                     phase_end;

    assign phase_end = (phase == PHASE_LAST);
    // done lands in the last low cycle so the next command can start without a gap
    assign done = zero_done | (active && !high && phase_end && (remaining == PULSE_COUNT_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel       <= PIN_RESP;
            active    <= 1'b0;
            high      <= 1'b0;
            zero_done <= 1'b0;
            phase     <= '0;
            remaining <= '0;
        end else begin
            zero_done <= 1'b0;
            if (start) begin
                sel       <= pin;
                remaining <= count;
                phase     <= '0;
                active    <= (count != '0);
                high      <= (count != '0);
                zero_done <= (count == '0);
            end else if (active) begin
                if (phase_end) begin
                    phase <= '0;
                    if (high) begin
                        high <= 1'b0;
                    end else if (remaining == PULSE_COUNT_W'(1)) begin
                        active <= 1'b0;
                    end else begin
                        remaining <= remaining - 1'b1;
                        high      <= 1'b1;
                    end
                end else begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

    assign resp = active && high && (sel == PIN_RESP);
    assign incp = active && high && (sel == PIN_INCP);
    assign resv = active && high && (sel == PIN_RESV);
    assign incv = active && high && (sel == PIN_INCV);

endmodule

// File: rtl/stonyman_controller.sv
// rtl/stonyman_controller.sv - Stonyman frame readout sequencer; STONYMAN_DOWNSAMPLE_EN selects 2x pixel step
module stonyman_controller
    import stonyman_pkg::*;
#(
    parameter int NUM_ROWS      = 112,
    parameter int NUM_COLS      = 112,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       adc_capture_done,
    output logic       adc_capture_start,
    output logic       newline_sample,
    output logic       resp,
    output logic       incp,
    output logic       resv,
    output logic       incv,
    output logic       busy,
    output logic       frame_done,
    output logic [6:0] row_idx,
    output logic [6:0] col_idx
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PULSE_COUNT_W-1:0] STEP_COUNT = PULSE_COUNT_W'(PIXEL_STEP);

    state_t                   state;
    state_t                   state_next;
    logic                     sel_incp;
    logic [SW-1:0]            settle_cnt;
    logic [7:0]               row_next;
    logic [7:0]               col_next;
    logic                     last_row;
    logic                     last_col;
    logic                     pg_start;
    logic                     pg_done;
    pin_t                     pg_pin;
    logic [PULSE_COUNT_W-1:0] pg_count;

    assign row_next = {1'b0, row_idx} + 8'(PIXEL_STEP);
    assign col_next = {1'b0, col_idx} + 8'(PIXEL_STEP);
    assign last_row = (row_next >= 8'(NUM_ROWS));
    assign last_col = (col_next >= 8'(NUM_COLS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // sel_incp: inside SEL_ROW/SEL_COL, 0 while resp runs and 1 while incp runs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_incp   <= 1'b0;
            settle_cnt <= '0;
            row_idx    <= '0;
            col_idx    <= '0;
        end else begin
            if (state == SEL_ROW || state == SEL_COL) begin
                if (pg_done) sel_incp <= ~sel_incp;
            end else begin
                sel_incp <= 1'b0;
            end
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
            if (state == WAIT_ADC && adc_capture_done && !last_col) col_idx <= col_next[6:0];
            if (state == NEXT_ROW) begin
                col_idx <= '0;
                row_idx <= last_row ? 7'd0 : row_next[6:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (frame_start) state_next = SEL_ROW;
            SEL_ROW:  if (pg_done && sel_incp) state_next = (row_idx == 7'd0) ? CLR_ROW : STEP_ROW;
            CLR_ROW:  if (pg_done) state_next = NEWLINE;
            STEP_ROW: if (pg_done) state_next = NEWLINE;
            NEWLINE:  state_next = SEL_COL;
            SEL_COL:  if (pg_done && sel_incp) state_next = CLR_COL;
            CLR_COL:  if (pg_done) state_next = SETTLE;
            SETTLE:   if (settle_cnt == SETTLE_LAST) state_next = CAPTURE;
            CAPTURE:  state_next = WAIT_ADC;
            WAIT_ADC: if (adc_capture_done) state_next = last_col ? NEXT_ROW : STEP_COL;
            STEP_COL: if (pg_done) state_next = SETTLE;
            NEXT_ROW: state_next = last_row ? DONE : SEL_ROW;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Pulse commands are issued on the transition so the pin rises in the first cycle of the new step
    always_comb begin
        pg_start          = 1'b0;
        pg_pin            = PIN_RESP;
        pg_count          = '0;
        busy              = (state != IDLE) && (state != DONE);
        frame_done        = (state == DONE);
        newline_sample    = (state == NEWLINE);
        adc_capture_start = (state == CAPTURE);
        case (state)
            IDLE: if (frame_start) begin
                pg_start = 1'b1;
                pg_count = PULSE_COUNT_W'(1);
            end
            SEL_ROW: if (pg_done) begin
                pg_start = 1'b1;
                if (!sel_incp) begin
                    pg_pin   = PIN_INCP;
                    pg_count = PULSE_COUNT_W'(ROWSEL);
                end else if (row_idx == 7'd0) begin
                    pg_pin   = PIN_RESV;
                    pg_count = PULSE_COUNT_W'(1);
                end else begin
                    pg_pin   = PIN_INCV;
                    pg_count = STEP_COUNT;
                end
            end
            NEWLINE: begin
                pg_start = 1'b1;
                pg_count = PULSE_COUNT_W'(1);
            end
            // the value register is cleared only on the first row; later rows keep it
            SEL_COL: if (pg_done) begin
                pg_start = 1'b1;
                if (!sel_incp) begin
                    pg_pin   = PIN_INCP;
                    pg_count = PULSE_COUNT_W'(COLSEL);
                end else begin
                    pg_pin   = PIN_RESV;
                    pg_count = {{(PULSE_COUNT_W-1){1'b0}}, (row_idx == 7'd0)};
                end
            end
            WAIT_ADC: if (adc_capture_done && !last_col) begin
                pg_start = 1'b1;
                pg_pin   = PIN_INCV;
                pg_count = STEP_COUNT;
            end
            NEXT_ROW: if (!last_row) begin
                pg_start = 1'b1;
                pg_count = PULSE_COUNT_W'(1);
            end
            default: ;
        endcase
    end

    stonyman_pulse_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_pulse_gen (
        .clk   (clk),
        .reset (reset),
        .start (pg_start),
        .pin   (pg_pin),
        .count (pg_count),
        .done  (pg_done),
        .resp  (resp),
        .incp  (incp),
        .resv  (resv),
        .incv  (incv)
    );

endmodule

// File: tb/tb_stonyman_controller.sv
// tb/tb_stonyman_controller.sv - directed self-checking bench for stonyman_controller
module tb_stonyman_controller;

`ifdef STONYMAN_DOWNSAMPLE_EN
    localparam int ROWS = 4, COLS = 4, N_PIX = 4, PIX_PER_ROW = 2, EXP_INCV = 6, SPUR_DLY = 36;
    localparam int EXP_PIX [0:3] = '{0, 2, 32, 34};
`else
    localparam int ROWS = 2, COLS = 3, N_PIX = 6, PIX_PER_ROW = 3, EXP_INCV = 5, SPUR_DLY = 30;
    localparam int EXP_PIX [0:5] = '{0, 1, 2, 16, 17, 18};
`endif
    localparam int P = 3, S = 8, ADC_LAT = 20;

    logic       clk = 1'b0;
    logic       reset, frame_start, spur_done;
    logic       adc_model_done = 1'b0;
    logic       adc_capture_done;
    logic       adc_capture_start, newline_sample, resp, incp, resv, incv, busy, frame_done;
    logic [6:0] row_idx, col_idx;

    assign adc_capture_done = adc_model_done | spur_done;

    always #5 clk = ~clk;

    stonyman_controller #(
        .NUM_ROWS(ROWS), .NUM_COLS(COLS), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .adc_capture_done(adc_capture_done),
        .adc_capture_start(adc_capture_start), .newline_sample(newline_sample),
        .resp(resp), .incp(incp), .resv(resv), .incv(incv),
        .busy(busy), .frame_done(frame_done), .row_idx(row_idx), .col_idx(col_idx)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0, n_cap, n_newline, n_done, n_resp, n_incp, n_resv, n_incv;
    int onehot_err, gap_err, hi_run = 0, lo_run = 100, resv_fall = 0;
    logic [3:0] pins, last_pins = 4'b0;
    int cap_q[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        pins = {resp, incp, resv, incv};
        if (reset) begin
            hi_run = 0; lo_run = 100; last_pins = 4'b0;
        end else begin
            if ($countones(pins) > 1) onehot_err++;
            if (pins != 4'b0) begin
                if (hi_run == 0) begin
                    if (lo_run < P) gap_err++;
                    case (pins)
                        4'b1000: n_resp++;
                        4'b0100: n_incp++;
                        4'b0010: n_resv++;
                        4'b0001: n_incv++;
                        default: ;
                    endcase
                end
                hi_run++;
                lo_run = 0;
            end else begin
                if (hi_run != 0) begin
                    check_eq("pulse_high_len", hi_run, P);
                    if (last_pins == 4'b0010) resv_fall = cyc;
                end
                hi_run = 0;
                lo_run++;
            end
            last_pins = pins;
            if (adc_capture_start) begin
                if (n_cap == 0) check_eq("settle_gap", cyc - resv_fall, P + S);
                cap_q.push_back(int'(row_idx) * 16 + int'(col_idx));
                n_cap++;
            end
            if (newline_sample) n_newline++;
            if (frame_done) n_done++;
        end
    end

    int adc_timer = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            adc_model_done = 1'b0;
            if (reset) adc_timer = 0;
            else if (adc_capture_start) adc_timer = ADC_LAT;
            else if (adc_timer > 0) begin
                adc_timer--;
                if (adc_timer == 0) adc_model_done = 1'b1;
            end
        end
    end

    function automatic int outs();
        return int'({busy, frame_done, adc_capture_start, newline_sample,
                     resp, incp, resv, incv, row_idx, col_idx});
    endfunction

    task automatic clear_counts();
        n_cap = 0; n_newline = 0; n_done = 0;
        n_resp = 0; n_incp = 0; n_resv = 0; n_incv = 0;
        onehot_err = 0; gap_err = 0;
        cap_q.delete();
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done();
        int b = 0;
        while (n_done == 0 && b < 4000) begin
            @(negedge clk);
            b++;
        end
        check_eq("frame_done_seen", int'(n_done != 0), 1);
    endtask

    task automatic check_frame();
        check_eq("captures", n_cap, N_PIX);
        check_eq("newlines", n_newline, 2);
        check_eq("frame_dones", n_done, 1);
        check_eq("busy_at_done", busy, 0);
        check_eq("resv_pulses", n_resv, 2);
        check_eq("resp_pulses", n_resp, 4);
        check_eq("incp_pulses", n_incp, 2);
        check_eq("incv_pulses", n_incv, EXP_INCV);
        check_eq("pin_onehot_err", onehot_err, 0);
        check_eq("pulse_low_gap_err", gap_err, 0);
        check_eq("row_wrap", row_idx, 0);
        check_eq("col_wrap", col_idx, 0);
        for (int i = 0; i < N_PIX; i++)
            check_eq("pixel_idx", (i < cap_q.size()) ? cap_q[i] : -1, EXP_PIX[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        reset = 1'b1; frame_start = 1'b0; spur_done = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", outs(), 0);

        frame_start = 1'b1;
        @(negedge clk);
        check_eq("reset_beats_start", busy, 0);
        frame_start = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_after_reset", busy, 0);

        // plain frame
        clear_counts();
        pulse_start();
        check_eq("busy_on_accept", busy, 1);
        check_eq("resp_on_accept", resp, 1);
        wait_done();
        check_frame();
        @(negedge clk);
        check_eq("busy_after_frame", busy, 0);

        // frame_start while in WAIT_ADC, stray adc_capture_done while settling
        clear_counts();
        pulse_start();
        b = 0;
        while (n_cap < 1 && b < 2000) begin @(negedge clk); b++; end
        check_eq("first_capture_seen", int'(n_cap >= 1), 1);
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (SPUR_DLY - 6) @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        wait_done();
        check_frame();
        repeat (40) @(negedge clk);
        check_eq("no_queued_frame", n_done, 1);
        check_eq("idle_no_queue", busy, 0);

        // reset while the second row steps its value register
        clear_counts();
        pulse_start();
        b = 0;
        while (n_cap < PIX_PER_ROW && b < 2000) begin @(negedge clk); b++; end
        while (!incv && b < 2000) begin @(negedge clk); b++; end
        check_eq("step_row_seen", int'(incv), 1);
        reset = 1'b1;
        #1;
        check_eq("abort_outputs", outs(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("abort_no_done", n_done, 0);
        check_eq("abort_idle", busy, 0);

        clear_counts();
        pulse_start();
        wait_done();
        check_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
